reg_file_scoreboard: RTL and testbench

- Architectural register file. It is the receiving end of the write-back path: it consumes `ans_wb` from the write-back block and serves operands to decode.
- Holds NREG x DATA_W registers with two registered read ports and one write port.
- Includes a per-register pending scoreboard. Decode marks a destination at issue; write-back clears it. A stall is raised when an operand or destination is still in flight.
- Sits between write-back (write side) and decode/issue (read side) of the 16-bit MIPS pipeline.

---
 rtl/reg_file_scoreboard_if.sv | 33 +++
 rtl/reg_file_scoreboard.sv | 77 +++++++
 tb/tb_reg_file_scoreboard.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_scoreboard_if.sv
// Operand/write-back bus between the pipeline (master) and the register file with scoreboard (slave).
interface reg_file_scoreboard_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned NREG   = 8
);
  logic [DATA_W-1:0] ans_wb;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              issue_valid;
  logic              issue_writes;
  logic [ADDR_W-1:0] issue_dest;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              stall;
  logic              issue_accept;
  logic [NREG-1:0]   pending;
  logic              wb_err;

  modport master (
    output ans_wb, wb_en, wb_addr, rd_addr_a, rd_addr_b,
           issue_valid, issue_writes, issue_dest,
    input  rd_data_a, rd_data_b, stall, issue_accept, pending, wb_err
  );

  modport slave (
    input  ans_wb, wb_en, wb_addr, rd_addr_a, rd_addr_b,
           issue_valid, issue_writes, issue_dest,
    output rd_data_a, rd_data_b, stall, issue_accept, pending, wb_err
  );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Architectural register file (R0 = 0) with two registered read ports, write-through
// bypass, and a per-register pending scoreboard that stalls RAW/WAW hazards at issue.
module reg_file_scoreboard #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned NREG   = 2 ** ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  reg_file_scoreboard_if.slave  bus
);

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_pending;
  logic [DATA_W-1:0] r_rd_data_a;
  logic [DATA_W-1:0] r_rd_data_b;
  logic              r_wb_err;

  logic              w_wr;
  logic [NREG-1:0]   w_clr;
  logic [NREG-1:0]   w_set;
  logic [NREG-1:0]   w_pend_eff;
  logic [NREG-1:0]   w_pend_nxt;
  logic              w_stall;
  logic              w_accept;
  logic [DATA_W-1:0] w_rd_a_nxt;
  logic [DATA_W-1:0] w_rd_b_nxt;

  // A register being written back this cycle is ready: its data is bypassed to the reader.
  always_comb begin
    w_wr       = bus.wb_en && (bus.wb_addr != '0);
    w_clr      = w_wr ? (NREG'(1) << bus.wb_addr) : '0;
    w_pend_eff = r_pending & ~w_clr;
    w_stall    = bus.issue_valid &
                 (w_pend_eff[bus.rd_addr_a] | w_pend_eff[bus.rd_addr_b] |
                  (bus.issue_writes & w_pend_eff[bus.issue_dest]));
    w_accept   = bus.issue_valid & ~w_stall;
    w_set      = (w_accept && bus.issue_writes && (bus.issue_dest != '0))
                 ? (NREG'(1) << bus.issue_dest) : '0;
    // Set after clear so a same-cycle retire and re-issue leaves the register in flight.
    w_pend_nxt = ((r_pending & ~w_clr) | w_set) & ~NREG'(1);
  end

  // Read-next muxes: R0 reads zero, same-cycle write-back wins over stored data.
  always_comb begin
    w_rd_a_nxt = r_regs[bus.rd_addr_a];
    w_rd_b_nxt = r_regs[bus.rd_addr_b];
    if (w_wr && (bus.wb_addr == bus.rd_addr_a)) w_rd_a_nxt = bus.ans_wb;
    if (w_wr && (bus.wb_addr == bus.rd_addr_b)) w_rd_b_nxt = bus.ans_wb;
    if (bus.rd_addr_a == '0) w_rd_a_nxt = '0;
    if (bus.rd_addr_b == '0) w_rd_b_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) r_regs[i] <= '0;
      r_pending   <= '0;
      r_rd_data_a <= '0;
      r_rd_data_b <= '0;
      r_wb_err    <= 1'b0;
    end else begin
      if (w_wr) r_regs[bus.wb_addr] <= bus.ans_wb;
      if (w_wr && !r_pending[bus.wb_addr]) r_wb_err <= 1'b1;
      r_pending   <= w_pend_nxt;
      r_rd_data_a <= w_rd_a_nxt;
      r_rd_data_b <= w_rd_b_nxt;
    end
  end

  assign bus.rd_data_a    = r_rd_data_a;
  assign bus.rd_data_b    = r_rd_data_b;
  assign bus.stall        = w_stall;
  assign bus.issue_accept = w_accept;
  assign bus.pending      = r_pending;
  assign bus.wb_err       = r_wb_err;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Self-checking bench for reg_file_scoreboard: directed scenarios plus randomized traffic
// checked against an array/flag reference model of the register file and scoreboard.
module tb_reg_file_scoreboard;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  reg_file_scoreboard_if #(.DATA_W(16), .ADDR_W(3), .NREG(8)) bus ();

  reg_file_scoreboard #(.DATA_W(16), .ADDR_W(3), .NREG(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: architectural state as plain arrays and flags.
  logic [15:0] m_reg  [8];
  bit          m_pend [8];
  bit          m_err;
  logic [15:0] m_rd_a;
  logic [15:0] m_rd_b;

  function automatic bit m_ready_blocked(input int r);
    return m_pend[r] && !(bus.wb_en && bus.wb_addr != 0 && int'(bus.wb_addr) == r);
  endfunction

  function automatic bit m_stall();
    return bus.issue_valid && (m_ready_blocked(int'(bus.rd_addr_a)) ||
           m_ready_blocked(int'(bus.rd_addr_b)) ||
           (bus.issue_writes && m_ready_blocked(int'(bus.issue_dest))));
  endfunction

  function automatic logic [7:0] m_pend_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic logic [15:0] m_read(input int a);
    if (a == 0) return 16'h0;
    if (bus.wb_en && int'(bus.wb_addr) == a) return bus.ans_wb;
    return m_reg[a];
  endfunction

  task automatic drive(input bit wen, input int wa, input logic [15:0] d,
                       input int ra, input int rb,
                       input bit iv, input bit iw, input int id);
    bus.wb_en        = wen;
    bus.wb_addr      = 3'(wa);
    bus.ans_wb       = d;
    bus.rd_addr_a    = 3'(ra);
    bus.rd_addr_b    = 3'(rb);
    bus.issue_valid  = iv;
    bus.issue_writes = iw;
    bus.issue_dest   = 3'(id);
    #1;
  endtask

  // Advance one clock, evolving the model from the inputs presented before the edge.
  task automatic tick();
    bit acc;
    bit wr;
    if (reset) begin
      for (int i = 0; i < 8; i++) begin m_reg[i] = 16'h0; m_pend[i] = 1'b0; end
      m_err = 1'b0; m_rd_a = 16'h0; m_rd_b = 16'h0;
    end else begin
      acc = bus.issue_valid && !m_stall();
      wr  = bus.wb_en && bus.wb_addr != 0;
      m_rd_a = m_read(int'(bus.rd_addr_a));
      m_rd_b = m_read(int'(bus.rd_addr_b));
      if (wr) begin
        if (!m_pend[bus.wb_addr]) m_err = 1'b1;
        m_reg[bus.wb_addr]  = bus.ans_wb;
        m_pend[bus.wb_addr] = 1'b0;
      end
      if (acc && bus.issue_writes && bus.issue_dest != 0) m_pend[bus.issue_dest] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 16'h0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 16'h0, i, 7 - i, 1, 0, 0);
      checks++;
      if (bus.stall !== 1'b0) begin
        errors++; $display("FAIL reset_stall addr=%0d got=%b exp=0", i, bus.stall);
      end
      tick();
      checks++;
      if (bus.rd_data_a !== 16'h0 || bus.rd_data_b !== 16'h0) begin
        errors++;
        $display("FAIL reset_read addr=%0d got a=%h b=%h exp 0", i, bus.rd_data_a, bus.rd_data_b);
      end
    end
    checks++;
    if (bus.pending !== 8'h00 || bus.wb_err !== 1'b0) begin
      errors++; $display("FAIL reset_state pending=%h wb_err=%b exp 00/0", bus.pending, bus.wb_err);
    end
  endtask

  task automatic test_round_trip();
    drive(0, 0, 16'h0, 0, 0, 1, 1, 3);
    tick();
    drive(0, 0, 16'h0, 3, 0, 1, 1, 4);
    checks++;
    if (bus.stall !== 1'b1 || bus.issue_accept !== 1'b0 || bus.pending !== 8'h08) begin
      errors++;
      $display("FAIL raw_stall got stall=%b acc=%b pend=%h exp 1/0/08",
               bus.stall, bus.issue_accept, bus.pending);
    end
    drive(1, 3, 16'hAAAA, 3, 0, 1, 0, 0);
    checks++;
    if (bus.stall !== 1'b0 || bus.issue_accept !== 1'b1) begin
      errors++; $display("FAIL bypass_stall got stall=%b acc=%b exp 0/1", bus.stall, bus.issue_accept);
    end
    tick();
    checks++;
    if (bus.rd_data_a !== 16'hAAAA || bus.pending !== 8'h00 || bus.wb_err !== 1'b0) begin
      errors++;
      $display("FAIL bypass_data got a=%h pend=%h err=%b exp AAAA/00/0",
               bus.rd_data_a, bus.pending, bus.wb_err);
    end
  endtask

  task automatic test_set_clear();
    drive(0, 0, 16'h0, 0, 0, 1, 1, 5);
    tick();
    drive(1, 5, 16'hFFFF, 0, 0, 1, 1, 5);
    checks++;
    if (bus.issue_accept !== 1'b1) begin
      errors++; $display("FAIL setclr_accept got=%b exp=1", bus.issue_accept);
    end
    tick();
    checks++;
    if (bus.pending[5] !== 1'b1 || bus.wb_err !== 1'b0) begin
      errors++; $display("FAIL setclr_pend got pend=%h err=%b exp bit5=1 err=0", bus.pending, bus.wb_err);
    end
    drive(0, 0, 16'h0, 5, 5, 0, 0, 0);
    tick();
    checks++;
    if (bus.rd_data_a !== 16'hFFFF || bus.rd_data_b !== 16'hFFFF) begin
      errors++; $display("FAIL setclr_reg got a=%h b=%h exp FFFF", bus.rd_data_a, bus.rd_data_b);
    end
  endtask

  task automatic test_r0();
    drive(1, 0, 16'hCCCC, 0, 0, 1, 1, 0);
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++; $display("FAIL r0_stall got=%b exp=0", bus.stall);
    end
    tick();
    checks++;
    if (bus.rd_data_a !== 16'h0 || bus.pending[0] !== 1'b0 || bus.wb_err !== 1'b0) begin
      errors++;
      $display("FAIL r0_rules got a=%h pend=%h err=%b exp 0/bit0=0/0",
               bus.rd_data_a, bus.pending, bus.wb_err);
    end
  endtask

  task automatic test_waw_error();
    drive(0, 0, 16'h0, 0, 0, 1, 1, 2);
    tick();
    drive(0, 0, 16'h0, 0, 0, 1, 1, 2);
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++; $display("FAIL waw_stall got=%b exp=1", bus.stall);
    end
    drive(1, 4, 16'hF0F0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 16'h0, 4, 0, 0, 0, 0);
    tick();
    checks++;
    if (bus.rd_data_a !== 16'hF0F0 || bus.wb_err !== 1'b1) begin
      errors++; $display("FAIL wb_err_set got a=%h err=%b exp F0F0/1", bus.rd_data_a, bus.wb_err);
    end
    idle();
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (bus.wb_err !== 1'b1) begin
      errors++; $display("FAIL wb_err_sticky got=%b exp=1", bus.wb_err);
    end
  endtask

  task automatic test_reset_midflight();
    drive(0, 0, 16'h0, 0, 0, 1, 1, 3);
    tick();
    checks++;
    if ((bus.pending & 8'h0C) !== 8'h0C) begin
      errors++; $display("FAIL midflight_setup got pend=%h exp bits 2,3 set", bus.pending);
    end
    reset = 1'b1;
    drive(1, 2, 16'h1234, 2, 3, 1, 1, 6);
    tick();
    reset = 1'b0;
    checks++;
    if (bus.pending !== 8'h00 || bus.rd_data_a !== 16'h0 || bus.rd_data_b !== 16'h0 ||
        bus.wb_err !== 1'b0) begin
      errors++;
      $display("FAIL midflight_reset got pend=%h a=%h b=%h err=%b exp 00/0/0/0",
               bus.pending, bus.rd_data_a, bus.rd_data_b, bus.wb_err);
    end
    drive(0, 0, 16'h0, 2, 4, 0, 0, 0);
    tick();
    checks++;
    if (bus.rd_data_a !== 16'h0 || bus.rd_data_b !== 16'h0) begin
      errors++; $display("FAIL midflight_regs got a=%h b=%h exp 0", bus.rd_data_a, bus.rd_data_b);
    end
  endtask

  // Dependent chain: each issue reads the register written back in the same cycle.
  task automatic test_back_to_back();
    for (int i = 1; i <= 7; i++) begin
      drive(i > 1, i - 1, 16'(16'h1000 + i - 1), i - 1, 0, i < 7, i < 7, i);
      checks++;
      if (bus.stall !== 1'b0) begin
        errors++; $display("FAIL b2b_stall step=%0d got=%b exp=0", i, bus.stall);
      end
      tick();
      checks++;
      if (bus.rd_data_a !== (i > 1 ? 16'(16'h1000 + i - 1) : 16'h0)) begin
        errors++; $display("FAIL b2b_data step=%0d got=%h", i, bus.rd_data_a);
      end
    end
    checks++;
    if (bus.pending !== 8'h00 || bus.wb_err !== 1'b0) begin
      errors++; $display("FAIL b2b_final got pend=%h err=%b exp 00/0", bus.pending, bus.wb_err);
    end
  endtask

  task automatic test_random();
    int pick;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      pick = int'($urandom_range(0, 7));
      // Bias write-backs toward in-flight registers so wb_err stays mostly meaningful.
      for (int k = 0; k < 8; k++) if (m_pend[(pick + k) % 8]) begin pick = (pick + k) % 8; break; end
      drive($urandom_range(0, 1) == 1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : pick,
            16'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)));
      checks++;
      if (bus.stall !== m_stall() || bus.issue_accept !== (bus.issue_valid && !m_stall())) begin
        errors++;
        $display("FAIL rand_stall cyc=%0d got stall=%b acc=%b exp stall=%b",
                 n, bus.stall, bus.issue_accept, m_stall());
      end
      tick();
      checks++;
      if (bus.rd_data_a !== m_rd_a || bus.rd_data_b !== m_rd_b) begin
        errors++;
        $display("FAIL rand_read cyc=%0d got a=%h b=%h exp a=%h b=%h",
                 n, bus.rd_data_a, bus.rd_data_b, m_rd_a, m_rd_b);
      end
      checks++;
      if (bus.pending !== m_pend_vec() || bus.wb_err !== m_err) begin
        errors++;
        $display("FAIL rand_state cyc=%0d got pend=%h err=%b exp pend=%h err=%b",
                 n, bus.pending, bus.wb_err, m_pend_vec(), m_err);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_round_trip();
    test_set_clear();
    test_r0();
    test_waw_error();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
